// File: rtl/output_unit.sv
// Output stage: buffers CPU output bytes in a small FIFO, converts each to
// decimal with a sequential double-dabble engine and streams the digits MSD first.
module output_unit #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in,
  input  logic         load,
  output logic [3:0]   digit,
  output logic         digit_valid,
  input  logic         digit_ready,
  output logic         digit_last,
  output logic         full,
  output logic         empty,
  output logic         busy,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

  state_t         state, state_next;
  logic [W-1:0]   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [7:0]     shreg;
  logic [11:0]    bcd, bcd_adj, bcd_shift;
  logic [2:0]     iter;
  logic [1:0]     sel, sel_start;
  logic           push, pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign busy  = (state != IDLE);
  assign push  = load & ~full;
  assign pop   = (state == IDLE) & ~empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (load && full) overflow <= 1'b1;
    end
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[10:0], shreg[7]};
    if (bcd_shift[11:8] != 4'd0)     sel_start = 2'd2;
    else if (bcd_shift[7:4] != 4'd0) sel_start = 2'd1;
    else                             sel_start = 2'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    digit       = 4'd0;
    digit_valid = 1'b0;
    digit_last  = 1'b0;
    case (state)
      IDLE: if (!empty) state_next = CONV;
      CONV: if (iter == 3'd7) state_next = EMIT;
      EMIT: begin
        digit_valid = 1'b1;
        case (sel)
          2'd2:    digit = bcd[11:8];
          2'd1:    digit = bcd[7:4];
          default: digit = bcd[3:0];
        endcase
        digit_last = (sel == 2'd0);
        if (digit_ready && sel == 2'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // sel walks hundreds(2) -> tens(1) -> ones(0) as the sink accepts digits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      bcd   <= '0;
      iter  <= '0;
      sel   <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          shreg <= mem[rd_ptr];
          bcd   <= '0;
          iter  <= '0;
        end
        CONV: begin
          bcd   <= bcd_shift;
          shreg <= {shreg[6:0], 1'b0};
          iter  <= iter + 1'b1;
          if (iter == 3'd7) sel <= sel_start;
        end
        EMIT: if (digit_ready && sel != 2'd0) sel <= sel - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_output_unit.sv
// Testbench for output_unit: directed and random stimulus checked every cycle
// against a queue-based decimal model of the FIFO and digit stream.
module tb_output_unit;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       ld;
  logic       rdy;
  logic [3:0] digit;
  logic       digit_valid, digit_last, full, empty, busy, overflow;

  int checks = 0;
  int errors = 0;

  // reference model state
  int q[$];
  int m_digits[$];
  int phase;
  int conv_left;
  bit m_ovf;

  // digits accepted by the sink, observed from the DUT
  int got[$];
  int exp_q[$];
  int got_last;

  output_unit #(.DEPTH(DEPTH), .W(8)) dut (
    .clk(clk), .reset(reset), .in(din), .load(ld),
    .digit(digit), .digit_valid(digit_valid), .digit_ready(rdy),
    .digit_last(digit_last), .full(full), .empty(empty),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_digits.delete();
    phase     = 0;
    conv_left = 0;
    m_ovf     = 1'b0;
  endtask

  // phase: 0 waiting for a byte, 1 converting, 2 presenting digits
  task automatic model_edge();
    bit was_full;
    int b;
    was_full = (q.size() == DEPTH);
    if (phase == 0) begin
      if (q.size() > 0) begin
        b = q.pop_front();
        m_digits.delete();
        if (b >= 100) m_digits.push_back(b / 100);
        if (b >= 10)  m_digits.push_back((b / 10) % 10);
        m_digits.push_back(b % 10);
        phase     = 1;
        conv_left = 8;
      end
    end else if (phase == 1) begin
      conv_left--;
      if (conv_left == 0) phase = 2;
    end else if (rdy) begin
      void'(m_digits.pop_front());
      if (m_digits.size() == 0) phase = 0;
    end
    if (ld) begin
      if (!was_full) q.push_back(int'(din));
      else           m_ovf = 1'b1;
    end
  endtask

  task automatic check_output();
    check("valid",    digit_valid, (phase == 2));
    check("last",     digit_last,  (phase == 2 && m_digits.size() == 1));
    if (phase == 2)      check("digit", digit, m_digits[0]);
    else if (phase == 0) check("digit_idle", digit, 0);
    check("full",     full,     (q.size() == DEPTH));
    check("empty",    empty,    (q.size() == 0));
    check("busy",     busy,     (phase != 0));
    check("overflow", overflow, m_ovf);
  endtask

  task automatic tick();
    if (digit_valid && rdy) begin
      got.push_back(int'(digit));
      if (digit_last) got_last++;
    end
    @(posedge clk);
    model_edge();
    #1;
    check_output();
  endtask

  task automatic apply_stimulus(input logic l, input logic [7:0] d, input logic r);
    ld  = l;
    din = d;
    rdy = r;
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    ld  = 1'b0;
    rdy = 1'b1;
    while ((phase != 0 || q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      errors++;
      $error("[TB] FAIL drain_timeout observed=%0d expected=%0d", phase, 0);
    end
    tick();
  endtask

  task automatic check_stream(input string tag, input int nlast);
    check({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check({tag, "_digit"}, got[i], exp_q[i]);
    check({tag, "_lastcnt"}, got_last, nlast);
    got.delete();
    got_last = 0;
  endtask

  initial begin
    reset = 1'b0;
    ld = 1'b0;
    din = 8'd0;
    rdy = 1'b0;
    got_last = 0;
    model_reset();
    #12;
    check_output();
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    // 123 with an always-ready sink
    apply_stimulus(1'b1, 8'd123, 1'b1);
    drain();
    exp_q = {1, 2, 3};
    check_stream("t123", 1);

    // zero and all-ones
    apply_stimulus(1'b1, 8'd0, 1'b1);
    drain();
    apply_stimulus(1'b1, 8'd255, 1'b1);
    drain();
    exp_q = {0, 2, 5, 5};
    check_stream("t0_255", 2);

    // back-to-back loads exercise leading-zero suppression
    apply_stimulus(1'b1, 8'd7, 1'b1);
    apply_stimulus(1'b1, 8'd40, 1'b1);
    apply_stimulus(1'b1, 8'd105, 1'b1);
    drain();
    exp_q = {7, 4, 0, 1, 0, 5};
    check_stream("tb2b", 3);

    // stalled sink must hold the digit
    apply_stimulus(1'b1, 8'd200, 1'b0);
    ld = 1'b0;
    for (int i = 0; i < 12 && phase != 2; i++) tick();
    for (int i = 0; i < 5; i++) tick();
    drain();
    exp_q = {2, 0, 0};
    check_stream("tstall", 1);

    // fill the FIFO and drop the sixth byte
    for (int i = 1; i <= 6; i++) apply_stimulus(1'b1, 8'(10 * i), 1'b0);
    ld = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    drain();
    exp_q = {1, 0, 2, 0, 3, 0, 4, 0, 5, 0};
    check_stream("tovf", 5);

    // reset in the middle of emitting 99
    apply_stimulus(1'b1, 8'd99, 1'b1);
    ld = 1'b0;
    for (int i = 0; i < 12 && phase != 2; i++) tick();
    tick();
    reset = 1'b0;
    #1;
    model_reset();
    check_output();
    got.delete();
    got_last = 0;
    #2;
    reset = 1'b1;
    apply_stimulus(1'b1, 8'd5, 1'b1);
    drain();
    exp_q = {5};
    check_stream("trst", 1);

    // random traffic with a random sink
    for (int i = 0; i < 400; i++)
      apply_stimulus(($urandom_range(3) == 0), 8'($urandom_range(255)), ($urandom_range(3) != 0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
